// File: rtl/irq_arbiter_pkg.sv
// irq_arbiter_pkg
// Shared definitions for the external interrupt arbiter:
//   - default parameter values (source count, priority width)
//   - byte offsets of the memory-mapped register window
//   - the "no interrupt" ID
//   - gateway FSM state encoding
//   - prio_offset(): byte offset of PRIORITY[idx]
package irq_arbiter_pkg;

    localparam int NUM_SRC_DEF = 8;
    localparam int PRIO_W_DEF  = 3;

    localparam logic [7:0] IRQ_PENDING   = 8'h00;
    localparam logic [7:0] IRQ_ENABLE    = 8'h04;
    localparam logic [7:0] IRQ_MODE      = 8'h08;
    localparam logic [7:0] IRQ_THRESH    = 8'h0C;
    localparam logic [7:0] IRQ_CLAIM     = 8'h10;
    localparam logic [7:0] IRQ_PRIO_BASE = 8'h20;

    localparam logic [7:0] IRQ_ID_NONE = 8'h00;

    typedef enum logic [1:0] {
        GW_IDLE    = 2'd0,
        GW_PEND    = 2'd1,
        GW_CLAIMED = 2'd2
    } gw_state_e;

    function automatic logic [7:0] prio_offset(input int idx);
        return IRQ_PRIO_BASE + 8'(4 * idx);
    endfunction

endpackage

// File: rtl/irq_arbiter_if.sv
// irq_arbiter_if
// Data-bus register window of the interrupt arbiter.
//   we/waddr/wdata : write strobe, address (byte offset in [7:0]), data
//   re/raddr       : read strobe (only qualifies the CLAIM side effect), address
//   rdata          : read data, combinational from raddr
// master = bus side (CPU), slave = arbiter side.
interface irq_arbiter_if;

    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        re;
    logic [31:0] raddr;
    logic [31:0] rdata;

    modport master (output we, waddr, wdata, re, raddr, input rdata);
    modport slave  (input we, waddr, wdata, re, raddr, output rdata);

endinterface

// File: rtl/irq_arbiter_gateway.sv
// irq_gateway
// Per-source interrupt gateway: 2-flop synchroniser, rising-edge detect and
// the IDLE/PEND/CLAIMED FSM with the edge-mode "again" flag.
//   clk, rst_n  : clock, async active-low reset
//   irq_raw     : raw asynchronous interrupt line
//   edge_mode   : 1 = edge triggered, 0 = level triggered
//   claim       : this source was claimed by software this cycle
//   complete    : software wrote this source's ID to COMPLETE this cycle
//   pending     : source is in PEND
module irq_gateway
    import irq_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic irq_raw,
    input  logic edge_mode,
    input  logic claim,
    input  logic complete,
    output logic pending
);

    logic      sync_meta;
    logic      sync_line;
    logic      line_prev;
    logic      rise;
    logic      again;
    gw_state_e state;

    // Two-flop synchroniser plus one extra flop to detect rising edges of the
    // synchronised line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync_line <= 1'b0;
            line_prev <= 1'b0;
        end else begin
            sync_meta <= irq_raw;
            sync_line <= sync_meta;
            line_prev <= sync_line;
        end
    end

    assign rise = sync_line & ~line_prev;

    // Gateway FSM. In edge mode, an edge arriving while the source is already
    // pending or being serviced is remembered once in 'again' and turns the
    // completion into a re-pend. In level mode the line itself decides whether
    // the source re-pends on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= GW_IDLE;
            again <= 1'b0;
        end else begin
            case (state)
                GW_IDLE: begin
                    if (edge_mode ? rise : sync_line) state <= GW_PEND;
                end
                GW_PEND: begin
                    if (edge_mode && rise) again <= 1'b1;
                    if (claim) state <= GW_CLAIMED;
                end
                GW_CLAIMED: begin
                    if (complete) begin
                        again <= 1'b0;
                        if (edge_mode) state <= (again || rise) ? GW_PEND : GW_IDLE;
                        else           state <= sync_line ? GW_PEND : GW_IDLE;
                    end else if (edge_mode && rise) begin
                        again <= 1'b1;
                    end
                end
                default: state <= GW_IDLE;
            endcase
        end
    end

    assign pending = (state == GW_PEND);

endmodule

// File: rtl/irq_arbiter.sv
// irq_arbiter
// External interrupt arbiter in front of clint. Holds the ENABLE / MODE /
// THRESHOLD / PRIORITY registers, one gateway per source, the priority
// selection and the registered request towards clint.
//   clk, rst_n    : clock, async active-low reset
//   irq_src_i     : raw asynchronous interrupt lines
//   bus           : register window (slave modport)
//   clint_busy_i  : freezes the registered arbitration result
//   irq_o         : registered external interrupt request
//   irq_id_o      : registered winner ID, 0 when irq_o = 0
module irq_arbiter
    import irq_arbiter_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int PRIO_W  = PRIO_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_src_i,
    irq_arbiter_if.slave       bus,
    input  logic               clint_busy_i,
    output logic               irq_o,
    output logic [7:0]         irq_id_o
);

    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] mode;
    logic [PRIO_W-1:0]  threshold;
    logic [PRIO_W-1:0]  prio [NUM_SRC];

    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] claim_vec;
    logic [NUM_SRC-1:0] complete_vec;

    logic               win_valid;
    logic [PRIO_W-1:0]  win_prio;
    logic [7:0]         win_id;

    logic [7:0]         woff;
    logic [7:0]         roff;
    logic               unused_addr_bits;

    assign woff = bus.waddr[7:0];
    assign roff = bus.raddr[7:0];

    // The upper address bits are decoded outside this block.
    assign unused_addr_bits = ^{bus.waddr[31:8], bus.raddr[31:8]};

    // Software-visible configuration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable    <= '0;
            mode      <= '0;
            threshold <= '0;
            for (int i = 0; i < NUM_SRC; i++) prio[i] <= '0;
        end else if (bus.we) begin
            if (woff == IRQ_ENABLE) enable    <= bus.wdata[NUM_SRC-1:0];
            if (woff == IRQ_MODE)   mode      <= bus.wdata[NUM_SRC-1:0];
            if (woff == IRQ_THRESH) threshold <= bus.wdata[PRIO_W-1:0];
            for (int i = 0; i < NUM_SRC; i++) begin
                if (woff == prio_offset(i)) prio[i] <= bus.wdata[PRIO_W-1:0];
            end
        end
    end

    // CLAIM targets the registered winner so software always claims the ID
    // that actually raised the interrupt; COMPLETE targets the written ID.
    always_comb begin
        claim_vec    = '0;
        complete_vec = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            claim_vec[i]    = bus.re && (roff == IRQ_CLAIM) && (irq_id_o == 8'(i + 1));
            complete_vec[i] = bus.we && (woff == IRQ_CLAIM) && (bus.wdata == 32'(i + 1));
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_gw
        irq_gateway u_gw (
            .clk       (clk),
            .rst_n     (rst_n),
            .irq_raw   (irq_src_i[g]),
            .edge_mode (mode[g]),
            .claim     (claim_vec[g]),
            .complete  (complete_vec[g]),
            .pending   (pending[g])
        );
    end

    // Priority selection: a strictly greater priority is needed to replace the
    // current candidate, so ties resolve to the lowest index.
    always_comb begin
        eligible  = '0;
        win_valid = 1'b0;
        win_prio  = '0;
        win_id    = IRQ_ID_NONE;
        for (int i = 0; i < NUM_SRC; i++) begin
            eligible[i] = pending[i] && enable[i] && (prio[i] > threshold);
            if (eligible[i] && (!win_valid || prio[i] > win_prio)) begin
                win_valid = 1'b1;
                win_prio  = prio[i];
                win_id    = 8'(i + 1);
            end
        end
    end

    // Output register; frozen while clint is busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_o    <= 1'b0;
            irq_id_o <= IRQ_ID_NONE;
        end else if (!clint_busy_i) begin
            irq_o    <= win_valid;
            irq_id_o <= win_id;
        end
    end

    // Read mux; unmapped offsets and unused high bits read as zero.
    always_comb begin
        bus.rdata = '0;
        case (roff)
            IRQ_PENDING: bus.rdata = 32'(pending);
            IRQ_ENABLE:  bus.rdata = 32'(enable);
            IRQ_MODE:    bus.rdata = 32'(mode);
            IRQ_THRESH:  bus.rdata = 32'(threshold);
            IRQ_CLAIM:   bus.rdata = 32'(irq_id_o);
            default:     bus.rdata = '0;
        endcase
        for (int i = 0; i < NUM_SRC; i++) begin
            if (roff == prio_offset(i)) bus.rdata = 32'(prio[i]);
        end
    end

endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter
// Self-checking bench for irq_arbiter: directed scenarios with fixed
// expectations, then a randomized run compared cycle by cycle with a
// behavioural model of the sources, registers and arbitration rules.
module tb_irq_arbiter;

    localparam int N = 8;

    localparam logic [31:0] A_PEND  = 32'h00;
    localparam logic [31:0] A_EN    = 32'h04;
    localparam logic [31:0] A_MODE  = 32'h08;
    localparam logic [31:0] A_THR   = 32'h0C;
    localparam logic [31:0] A_CLAIM = 32'h10;
    localparam logic [31:0] A_PRIO  = 32'h20;

    localparam int S_IDLE    = 0;
    localparam int S_PEND    = 1;
    localparam int S_CLAIMED = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] irq_src = '0;
    logic         busy = 1'b0;
    logic         irq;
    logic [7:0]   irq_id;

    irq_arbiter_if bus ();

    irq_arbiter #(.NUM_SRC(N), .PRIO_W(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_src_i    (irq_src),
        .bus          (bus),
        .clint_busy_i (busy),
        .irq_o        (irq),
        .irq_id_o     (irq_id)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    int       m_state [N];
    bit       m_again [N];
    bit [2:0] m_sync  [N];
    int       m_prio  [N];
    bit [7:0] m_en;
    bit [7:0] m_mode;
    int       m_thr;
    bit       m_irq;
    int       m_id;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_state[i] = S_IDLE;
            m_again[i] = 1'b0;
            m_sync[i]  = 3'b000;
            m_prio[i]  = 0;
        end
        m_en = '0; m_mode = '0; m_thr = 0; m_irq = 1'b0; m_id = 0;
    endtask

    // Highest priority first; within one priority the lowest index wins.
    function automatic int model_winner();
        for (int p = 7; p > m_thr; p--) begin
            for (int i = 0; i < N; i++) begin
                if (m_state[i] == S_PEND && m_en[i] && m_prio[i] == p) return i + 1;
            end
        end
        return 0;
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] off);
        logic [31:0] r;
        r = '0;
        if (off == 8'h00) begin
            for (int i = 0; i < N; i++) r[i] = (m_state[i] == S_PEND);
        end else if (off == 8'h04) r = 32'(m_en);
        else if (off == 8'h08) r = 32'(m_mode);
        else if (off == 8'h0C) r = 32'(m_thr);
        else if (off == 8'h10) r = 32'(m_id);
        else if (off >= 8'h20 && off < 8'h40 && off[1:0] == 2'b00)
            r = 32'(m_prio[int'((off - 8'h20) >> 2)]);
        return r;
    endfunction

    // One clock edge of the model, using the inputs present before the edge.
    task automatic model_step();
        int win;
        logic [7:0] wo;
        logic [7:0] ro;
        bit synced, rose, is_edge, claimed_now, completed_now;
        win = model_winner();
        wo = bus.waddr[7:0];
        ro = bus.raddr[7:0];
        for (int i = 0; i < N; i++) begin
            synced        = m_sync[i][1];
            rose          = m_sync[i][1] && !m_sync[i][2];
            is_edge       = m_mode[i];
            claimed_now   = bus.re && ro == 8'h10 && m_id == i + 1;
            completed_now = bus.we && wo == 8'h10 && bus.wdata == 32'(i + 1);
            if (m_state[i] == S_IDLE) begin
                if (is_edge ? rose : synced) m_state[i] = S_PEND;
            end else if (m_state[i] == S_PEND) begin
                if (is_edge && rose) m_again[i] = 1'b1;
                if (claimed_now) m_state[i] = S_CLAIMED;
            end else begin
                if (completed_now) begin
                    if (is_edge) m_state[i] = (m_again[i] || rose) ? S_PEND : S_IDLE;
                    else         m_state[i] = synced ? S_PEND : S_IDLE;
                    m_again[i] = 1'b0;
                end else if (is_edge && rose) begin
                    m_again[i] = 1'b1;
                end
            end
            m_sync[i] = {m_sync[i][1], m_sync[i][0], irq_src[i]};
        end
        if (bus.we) begin
            if (wo == 8'h04) m_en = bus.wdata[7:0];
            else if (wo == 8'h08) m_mode = bus.wdata[7:0];
            else if (wo == 8'h0C) m_thr = int'(bus.wdata[2:0]);
            else if (wo >= 8'h20 && wo < 8'h40 && wo[1:0] == 2'b00)
                m_prio[int'((wo - 8'h20) >> 2)] = int'(bus.wdata[2:0]);
        end
        if (!busy) begin
            m_irq = (win != 0);
            m_id  = win;
        end
    endtask

    // Inputs change at the falling edge; the model steps at the rising edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
    endtask

    task automatic wait_ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        irq_src = '0; busy = 1'b0;
        bus.we = 1'b0; bus.re = 1'b0; bus.waddr = '0; bus.wdata = '0; bus.raddr = '0;
        rst_n = 1'b0;
        model_reset();
        wait_ticks(2);
        rst_n = 1'b1;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        bus.we = 1'b1; bus.waddr = addr; bus.wdata = data;
        tick();
        bus.we = 1'b0;
    endtask

    task automatic bus_claim(output logic [31:0] got);
        bus.re = 1'b1; bus.raddr = A_CLAIM;
        #1 got = bus.rdata;
        tick();
        bus.re = 1'b0;
    endtask

    task automatic peek(input logic [31:0] addr, output logic [31:0] got);
        bus.raddr = addr;
        #1 got = bus.rdata;
    endtask

    task automatic pulse(input logic [N-1:0] mask);
        irq_src = mask;
        tick();
        irq_src = '0;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        logic [31:0] addrs [5];
        addrs = '{A_PEND, A_EN, A_MODE, A_THR, A_PRIO};
        do_reset();
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_irq: got %0b want 0", irq); end
        n_cmp++; if (irq_id !== 8'd0) begin n_bad++; $display("[TB] FAIL reset_id: got %0d want 0", irq_id); end
        for (int k = 0; k < 5; k++) begin
            peek(addrs[k], r);
            n_cmp++; if (r !== 32'd0) begin n_bad++; $display("[TB] FAIL reset_reg_%0h: got %0h want 0", addrs[k], r); end
        end
    endtask

    task automatic test_single_edge();
        logic [31:0] r;
        do_reset();
        bus_write(A_EN, 32'h01); bus_write(A_PRIO, 32'd1); bus_write(A_THR, 32'd0); bus_write(A_MODE, 32'h01);
        irq_src[0] = 1'b1;
        tick();
        irq_src[0] = 1'b0;
        wait_ticks(2);
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("[TB] FAIL t1_early: irq got %0b want 0 at edge 2", irq); end
        tick();
        n_cmp++; if (irq !== 1'b1 || irq_id !== 8'd1) begin n_bad++; $display("[TB] FAIL t1_raise: irq=%0b id=%0d want 1/1", irq, irq_id); end
        bus_claim(r);
        n_cmp++; if (r !== 32'd1) begin n_bad++; $display("[TB] FAIL t1_claim: got %0d want 1", r); end
        tick();
        n_cmp++; if (irq !== 1'b0 || irq_id !== 8'd0) begin n_bad++; $display("[TB] FAIL t1_drop: irq=%0b id=%0d want 0/0", irq, irq_id); end
        peek(A_PEND, r);
        n_cmp++; if (r !== 32'd0) begin n_bad++; $display("[TB] FAIL t1_pending: got %0h want 0", r); end
        bus_write(A_CLAIM, 32'd1);
    endtask

    task automatic test_tie_break();
        logic [31:0] r;
        do_reset();
        bus_write(A_EN, 32'h24); bus_write(A_PRIO + 8, 32'd5); bus_write(A_PRIO + 20, 32'd5); bus_write(A_MODE, 32'h24);
        pulse(8'h24);
        wait_ticks(3);
        n_cmp++; if (irq !== 1'b1 || irq_id !== 8'd3) begin n_bad++; $display("[TB] FAIL t2_tie: irq=%0b id=%0d want 1/3", irq, irq_id); end
        bus_claim(r);
        n_cmp++; if (r !== 32'd3) begin n_bad++; $display("[TB] FAIL t2_claim: got %0d want 3", r); end
        bus_write(A_CLAIM, 32'd3);
        tick();
        n_cmp++; if (irq !== 1'b1 || irq_id !== 8'd6) begin n_bad++; $display("[TB] FAIL t2_next: irq=%0b id=%0d want 1/6", irq, irq_id); end
    endtask

    task automatic test_threshold();
        logic [31:0] r;
        do_reset();
        bus_write(A_EN, 32'h02); bus_write(A_PRIO + 4, 32'd4); bus_write(A_THR, 32'd4); bus_write(A_MODE, 32'h02);
        pulse(8'h02);
        wait_ticks(4);
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("[TB] FAIL t3_masked: irq got %0b want 0", irq); end
        peek(A_PEND, r);
        n_cmp++; if (r !== 32'h02) begin n_bad++; $display("[TB] FAIL t3_pending: got %0h want 2", r); end
        bus_write(A_THR, 32'd3);
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("[TB] FAIL t3_same_cycle: irq got %0b want 0", irq); end
        tick();
        n_cmp++; if (irq !== 1'b1 || irq_id !== 8'd2) begin n_bad++; $display("[TB] FAIL t3_open: irq=%0b id=%0d want 1/2", irq, irq_id); end
    endtask

    task automatic test_edge_again();
        logic [31:0] r;
        do_reset();
        bus_write(A_EN, 32'h01); bus_write(A_PRIO, 32'd1); bus_write(A_MODE, 32'h01);
        pulse(8'h01);
        wait_ticks(3);
        bus_claim(r);
        n_cmp++; if (r !== 32'd1) begin n_bad++; $display("[TB] FAIL t4_claim1: got %0d want 1", r); end
        pulse(8'h01); wait_ticks(3);
        pulse(8'h01); wait_ticks(3);
        peek(A_PEND, r);
        n_cmp++; if (r !== 32'd0) begin n_bad++; $display("[TB] FAIL t4_held: pending got %0h want 0", r); end
        bus_write(A_CLAIM, 32'd1);
        tick();
        n_cmp++; if (irq !== 1'b1 || irq_id !== 8'd1) begin n_bad++; $display("[TB] FAIL t4_requeue: irq=%0b id=%0d want 1/1", irq, irq_id); end
        bus_claim(r);
        bus_write(A_CLAIM, 32'd1);
        wait_ticks(2);
        peek(A_PEND, r);
        n_cmp++; if (irq !== 1'b0 || r !== 32'd0) begin n_bad++; $display("[TB] FAIL t4_idle: irq=%0b pending=%0h want 0/0", irq, r); end
    endtask

    task automatic test_level();
        logic [31:0] r;
        do_reset();
        bus_write(A_EN, 32'h01); bus_write(A_PRIO, 32'd2); bus_write(A_PRIO + 12, 32'd1); bus_write(A_MODE, 32'h00);
        irq_src[0] = 1'b1;
        wait_ticks(4);
        n_cmp++; if (irq !== 1'b1 || irq_id !== 8'd1) begin n_bad++; $display("[TB] FAIL t5_raise: irq=%0b id=%0d want 1/1", irq, irq_id); end
        bus_claim(r);
        bus_write(A_CLAIM, 32'd1);
        tick();
        peek(A_PEND, r);
        n_cmp++; if (r !== 32'h01 || irq !== 1'b1) begin n_bad++; $display("[TB] FAIL t5_repend: pending=%0h irq=%0b want 1/1", r, irq); end
        bus_claim(r);
        irq_src[0] = 1'b0;
        wait_ticks(3);
        bus_write(A_CLAIM, 32'd1);
        irq_src[3] = 1'b1;
        tick();
        irq_src[3] = 1'b0;
        wait_ticks(4);
        bus_claim(r);
        n_cmp++; if (r !== 32'd0) begin n_bad++; $display("[TB] FAIL t5_empty_claim: got %0d want 0", r); end
        peek(A_PEND, r);
        n_cmp++; if (r !== 32'h08 || irq !== 1'b0) begin n_bad++; $display("[TB] FAIL t5_no_effect: pending=%0h irq=%0b want 8/0", r, irq); end
    endtask

    task automatic test_busy_and_reset();
        logic [31:0] r;
        do_reset();
        bus_write(A_EN, 32'h03); bus_write(A_PRIO, 32'd1); bus_write(A_PRIO + 4, 32'd6); bus_write(A_MODE, 32'h03);
        pulse(8'h01);
        wait_ticks(3);
        busy = 1'b1;
        pulse(8'h02);
        wait_ticks(4);
        n_cmp++; if (irq !== 1'b1 || irq_id !== 8'd1) begin n_bad++; $display("[TB] FAIL t6_hold: irq=%0b id=%0d want 1/1", irq, irq_id); end
        busy = 1'b0;
        tick();
        n_cmp++; if (irq_id !== 8'd2) begin n_bad++; $display("[TB] FAIL t6_release: id got %0d want 2", irq_id); end
        bus_claim(r);
        n_cmp++; if (r !== 32'd2) begin n_bad++; $display("[TB] FAIL t6_claim: got %0d want 2", r); end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        peek(A_PEND, r);
        n_cmp++; if (irq !== 1'b0 || irq_id !== 8'd0 || r !== 32'd0) begin n_bad++; $display("[TB] FAIL t6_async_reset: irq=%0b id=%0d pending=%0h want 0/0/0", irq, irq_id, r); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic [31:0] exp_r;
        int sel;
        do_reset();
        bus_write(A_EN, 32'hFF);
        for (int i = 0; i < N; i++) bus_write(A_PRIO + 32'(4 * i), 32'($urandom_range(0, 7)));
        bus_write(A_MODE, 32'($urandom_range(0, 255)));
        for (int c = 0; c < 600; c++) begin
            irq_src = 8'($urandom & $urandom & $urandom);
            busy = ($urandom_range(0, 3) == 0);
            bus.we = ($urandom_range(0, 3) == 0);
            sel = $urandom_range(0, 14);
            if (sel < 5) bus.waddr = 32'(4 * sel);
            else if (sel < 13) bus.waddr = A_PRIO + 32'(4 * (sel - 5));
            else bus.waddr = (sel == 13) ? 32'h48 : 32'h14;
            bus.waddr = bus.waddr | ($urandom & 32'hFFFF_FF00);
            if ($urandom_range(0, 1) == 1) bus.waddr = A_CLAIM;
            bus.wdata = (bus.waddr[7:0] == 8'h10) ? 32'($urandom_range(0, 9)) : $urandom;
            bus.re = ($urandom_range(0, 2) == 0);
            sel = $urandom_range(0, 15);
            if (sel < 5) bus.raddr = 32'(4 * sel);
            else if (sel < 13) bus.raddr = A_PRIO + 32'(4 * (sel - 5));
            else bus.raddr = (sel == 13) ? 32'h4C : A_CLAIM;
            #1;
            r = bus.rdata;
            exp_r = model_read(bus.raddr[7:0]);
            n_cmp++; if (r !== exp_r) begin n_bad++; $display("[TB] FAIL rnd_rdata c=%0d off=%0h: got %0h want %0h", c, bus.raddr[7:0], r, exp_r); end
            tick();
            n_cmp++; if (irq !== m_irq || irq_id !== 8'(m_id)) begin n_bad++; $display("[TB] FAIL rnd_out c=%0d: irq=%0b id=%0d want %0b/%0d", c, irq, irq_id, m_irq, m_id); end
        end
        bus.we = 1'b0; bus.re = 1'b0; busy = 1'b0; irq_src = '0;
    endtask

    initial begin
        bus.we = 1'b0; bus.re = 1'b0; bus.waddr = '0; bus.wdata = '0; bus.raddr = '0;
        model_reset();
        test_reset();
        test_single_edge();
        test_tie_break();
        test_threshold();
        test_edge_again();
        test_level();
        test_busy_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
